// File: rtl/nes_pkg.sv
// nes_pkg: shared definitions for the NES controller poll scheduler.
//   - state_t          : poll sequencer state encoding
//   - BTN_*            : bit index of each button in the 8-bit button words
//   - DEFAULT_TICK_DIV : default prescaler divide value (tick every N+1 clocks)
//   - NUM_BUTTONS, PULSE_REPEATS : frame geometry of one pad read
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH_HI,
    ST_LATCH_LO,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_DONE
  } state_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned NUM_BUTTONS      = 8;
  // Bit 0 comes out during LATCH_LO; the remaining bits need one pulse each.
  localparam int unsigned PULSE_REPEATS    = NUM_BUTTONS - 1;
  localparam int unsigned DEFAULT_TICK_DIV = 162;

endpackage

// File: rtl/nes_tick_gen.sv
// nes_tick_gen: prescaler producing the timing tick for the poll sequencer.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   restart : force the count back to 0 (phase-aligns ticks to a poll start)
//   enable  : advance the count; while low the count holds and no tick fires
//   tick    : one-cycle strobe on the last cycle of every TICK_DIV+1 cycle window
module nes_tick_gen
  import nes_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Derived straight from the count register, so the strobe is glitch-free
  // and lines up with the last cycle of each tick window.
  assign tick = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: reads two NES pads over a shared LATCH/PULSE bus, either
// periodically (ENABLE) or on demand (POLL_REQ), and publishes held and newly
// pressed button state.
//   CLOCK, RESET_N     : clock, asynchronous active-low reset
//   ENABLE             : run the periodic poll timer
//   POLL_REQ           : single-cycle on-demand poll request
//   DATA1, DATA2       : serial pad data, active low, asynchronous
//   LATCH, PULSE       : shared pad latch / shift-clock lines
//   BUSY               : poll in progress (first LATCH_HI cycle through DONE)
//   BUTTONS1/2         : held button state, 1 = pressed (bit 0 = A .. 7 = Right)
//   PRESSED1/2         : buttons that went from released to pressed in last poll
//   VALID              : one-cycle strobe when BUTTONS/PRESSED update
module nes_poll_scheduler
  import nes_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEFAULT_TICK_DIV,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       POLL_REQ,
  input  logic       DATA1,
  input  logic       DATA2,
  output logic       LATCH,
  output logic       PULSE,
  output logic       BUSY,
  output logic [7:0] BUTTONS1,
  output logic [7:0] BUTTONS2,
  output logic [7:0] PRESSED1,
  output logic [7:0] PRESSED2,
  output logic       VALID
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST     = PW'(POLL_PERIOD - 1);
  localparam logic [2:0]    LAST_PULSE = 3'(PULSE_REPEATS - 1);

  state_t        state;
  logic [1:0]    data_meta;
  logic [1:0]    data_sync;
  logic [1:0]    pad_bits;
  logic [PW-1:0] period_cnt;
  logic          expiry;
  logic          pending;
  logic          start;
  logic          tick;
  logic          tick_run;
  logic          latch_half;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr1;
  logic [7:0]    sr2;
  logic [7:0]    next1;
  logic [7:0]    next2;

  // Two-flop synchronizer; idle level of the pad lines is high (released).
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_meta <= '1;
      data_sync <= '1;
    end else begin
      data_meta <= {DATA2, DATA1};
      data_sync <= data_meta;
    end
  end

  assign pad_bits = ~data_sync;

  // Free-running period timer, held cleared while ENABLE is low.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      period_cnt <= '0;
    end else if (!ENABLE || expiry) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign expiry = ENABLE && (period_cnt == P_LAST);
  assign start  = (state == ST_IDLE) && (POLL_REQ || pending);

  assign tick_run = (state != ST_IDLE) && (state != ST_DONE);

  nes_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .restart (start),
    .enable  (tick_run),
    .tick    (tick)
  );

  // Bits are shifted in from the top, so after eight captures bit 0 holds A.
  // next1/next2 include the bit captured on the current tick, which lets the
  // final capture and the DONE-time publish happen on the same edge.
  assign next1 = {pad_bits[0], sr1[7:1]};
  assign next2 = {pad_bits[1], sr2[7:1]};

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      latch_half <= 1'b0;
      bit_cnt    <= '0;
      sr1        <= '0;
      sr2        <= '0;
      LATCH      <= 1'b0;
      PULSE      <= 1'b0;
      BUSY       <= 1'b0;
      VALID      <= 1'b0;
      BUTTONS1   <= '0;
      BUTTONS2   <= '0;
      PRESSED1   <= '0;
      PRESSED2   <= '0;
    end else begin
      VALID <= 1'b0;

      // One-deep request flag: any number of triggers collapse into one poll,
      // and a trigger coinciding with a poll start is absorbed by that poll.
      if (start) begin
        pending <= 1'b0;
      end else if (POLL_REQ || expiry) begin
        pending <= 1'b1;
      end

      // Outputs are assigned on the edge that enters each state so that the
      // registered LATCH/PULSE/VALID/BUTTONS values coincide with that state.
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LATCH_HI;
            LATCH      <= 1'b1;
            PULSE      <= 1'b0;
            BUSY       <= 1'b1;
            latch_half <= 1'b0;
            bit_cnt    <= '0;
          end
        end

        ST_LATCH_HI: begin
          if (tick) begin
            if (latch_half) begin
              state <= ST_LATCH_LO;
              LATCH <= 1'b0;
            end else begin
              latch_half <= 1'b1;
            end
          end
        end

        ST_LATCH_LO: begin
          if (tick) begin
            sr1   <= next1;
            sr2   <= next2;
            state <= ST_PULSE_HI;
            PULSE <= 1'b1;
          end
        end

        ST_PULSE_HI: begin
          if (tick) begin
            state <= ST_PULSE_LO;
            PULSE <= 1'b0;
          end
        end

        ST_PULSE_LO: begin
          if (tick) begin
            sr1 <= next1;
            sr2 <= next2;
            if (bit_cnt == LAST_PULSE) begin
              state    <= ST_DONE;
              VALID    <= 1'b1;
              BUTTONS1 <= next1;
              BUTTONS2 <= next2;
              PRESSED1 <= next1 & ~BUTTONS1;
              PRESSED2 <= next2 & ~BUTTONS2;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_PULSE_HI;
              PULSE   <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          LATCH <= 1'b0;
          PULSE <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb_nes_poll_scheduler: self-checking bench for nes_poll_scheduler with
// TICK_DIV = 3, POLL_PERIOD = 200. Two behavioural 4021-style pads drive the
// serial lines; expected button words come from the pad contents and the
// previously reported state.
module tb_nes_poll_scheduler;
  import nes_pkg::*;

  logic       CLOCK;
  logic       RESET_N;
  logic       ENABLE;
  logic       POLL_REQ;
  wire        DATA1;
  wire        DATA2;
  logic       LATCH;
  logic       PULSE;
  logic       BUSY;
  logic [7:0] BUTTONS1;
  logic [7:0] BUTTONS2;
  logic [7:0] PRESSED1;
  logic [7:0] PRESSED2;
  logic       VALID;

  int n_cmp  = 0;
  int n_fail = 0;

  nes_poll_scheduler #(
    .TICK_DIV    (3),
    .POLL_PERIOD (200)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .ENABLE   (ENABLE),
    .POLL_REQ (POLL_REQ),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .LATCH    (LATCH),
    .PULSE    (PULSE),
    .BUSY     (BUSY),
    .BUTTONS1 (BUTTONS1),
    .BUTTONS2 (BUTTONS2),
    .PRESSED1 (PRESSED1),
    .PRESSED2 (PRESSED2),
    .VALID    (VALID)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Pad model: LATCH loads the buttons, each PULSE rise shifts to the next one.
  logic [7:0] pad1 = '0;
  logic [7:0] pad2 = '0;
  int pad_idx = 0;

  always @(posedge LATCH or posedge PULSE) begin
    if (LATCH) pad_idx = 0;
    else       pad_idx = pad_idx + 1;
  end

  assign DATA1 = (pad_idx < 8) ? ~pad1[pad_idx] : 1'b1;
  assign DATA2 = (pad_idx < 8) ? ~pad2[pad_idx] : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus protocol: never LATCH and PULSE together, both idle outside a poll.
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      n_cmp++;
      assert (!(LATCH && PULSE) && ((BUSY && !VALID) || (!LATCH && !PULSE)))
      else begin
        n_fail++;
        $display("FAIL protocol: LATCH=%b PULSE=%b BUSY=%b VALID=%b", LATCH, PULSE, BUSY, VALID);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // One on-demand poll with full timing checks and expected results.
  task automatic run_poll(input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] e_b1, input logic [7:0] e_b2,
                          input logic [7:0] e_pr1, input logic [7:0] e_pr2);
    int   c = 0;
    int   latch_cyc = 0;
    int   pulse_cyc = 0;
    int   pulse_rise = 0;
    logic prev_pulse = 1'b0;
    bit   got = 1'b0;
    pad1 = p1;
    pad2 = p2;
    @(posedge CLOCK); #1;
    POLL_REQ = 1'b1;
    chk("busy_before_start", BUSY, 1'b0);
    @(posedge CLOCK); #1;
    POLL_REQ = 1'b0;
    chk("busy_rise", BUSY, 1'b1);
    while (c < 200) begin
      if (VALID) begin
        got = 1'b1;
        break;
      end
      if (LATCH) latch_cyc++;
      if (PULSE) begin
        pulse_cyc++;
        if (!prev_pulse) pulse_rise++;
      end
      prev_pulse = PULSE;
      @(posedge CLOCK); #1;
      c++;
    end
    chk("valid_seen", got, 1'b1);
    chk("valid_latency", c, 68);
    chk("latch_cycles", latch_cyc, 8);
    chk("pulse_cycles", pulse_cyc, 28);
    chk("pulse_count", pulse_rise, 7);
    chk("busy_in_done", BUSY, 1'b1);
    chk("buttons1", BUTTONS1, e_b1);
    chk("buttons2", BUTTONS2, e_b2);
    chk("pressed1", PRESSED1, e_pr1);
    chk("pressed2", PRESSED2, e_pr2);
    @(posedge CLOCK); #1;
    chk("valid_one_cycle", VALID, 1'b0);
    chk("busy_drop", BUSY, 1'b0);
    chk("buttons1_hold", BUTTONS1, e_b1);
    chk("pressed1_hold", PRESSED1, e_pr1);
  endtask

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] pr1;
    logic [7:0] pr2;
  } vec_t;

  vec_t tab[6];
  logic [7:0] m_b1;
  logic [7:0] m_b2;
  logic [7:0] r1;
  logic [7:0] r2;
  int vt[$];
  int valids;
  int busy_seen;
  int rises;
  logic prev_p;

  initial begin
    tab[0] = '{8'h81, 8'h00, 8'h81, 8'h00, 8'h81, 8'h00};
    tab[1] = '{8'(1 << BTN_A), 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    tab[2] = '{8'((1 << BTN_A) | (1 << BTN_UP)), 8'h00, 8'h11, 8'h00, 8'h10, 8'h00};
    tab[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    tab[4] = '{8'hFF, 8'hA5, 8'hFF, 8'hA5, 8'hFF, 8'h00};
    tab[5] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h5A};

    RESET_N  = 1'b0;
    ENABLE   = 1'b0;
    POLL_REQ = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_latch", LATCH, 1'b0);
    chk("rst_pulse", PULSE, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_buttons", {BUTTONS2, BUTTONS1}, 16'h0000);
    chk("rst_pressed", {PRESSED2, PRESSED1}, 16'h0000);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLOCK);

    // Table-driven polls: single poll, edge detect, mixed patterns.
    for (int i = 0; i < 6; i++) begin
      run_poll(tab[i].p1, tab[i].p2, tab[i].b1, tab[i].b2, tab[i].pr1, tab[i].pr2);
    end
    m_b1 = 8'h5A;
    m_b2 = 8'h5A;

    // Coalescing: three requests during one busy window give one extra poll.
    pad1 = 8'h24;
    pad2 = 8'h42;
    valids = 0;
    for (int c = 0; c < 300; c++) begin
      POLL_REQ = (c == 0 || c == 15 || c == 40 || c == 66);
      if (VALID) valids++;
      @(posedge CLOCK); #1;
    end
    POLL_REQ = 1'b0;
    chk("coalesce_valids", valids, 2);
    chk("coalesce_buttons", {BUTTONS2, BUTTONS1}, 16'h4224);
    chk("coalesce_pressed", {PRESSED2, PRESSED1}, 16'h0000);
    m_b1 = 8'h24;
    m_b2 = 8'h42;

    // Periodic polling: ENABLE sampled high on 1000 consecutive edges.
    pad1 = 8'hC3;
    pad2 = 8'h3C;
    ENABLE = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if (VALID) vt.push_back(c);
      if (c == 1000) ENABLE = 1'b0;
      @(posedge CLOCK); #1;
    end
    chk("periodic_count", vt.size(), 5);
    if (vt.size() > 0) chk("periodic_first", vt[0], 269);
    for (int i = 1; i < vt.size(); i++) chk("periodic_gap", vt[i] - vt[i-1], 200);
    chk("periodic_buttons", {BUTTONS2, BUTTONS1}, 16'h3CC3);
    m_b1 = 8'hC3;
    m_b2 = 8'h3C;

    // Request coinciding with period expiry: only one poll.
    pad1 = 8'h09;
    pad2 = 8'h90;
    ENABLE = 1'b1;
    repeat (199) @(posedge CLOCK);
    #1;
    POLL_REQ = 1'b1;
    @(posedge CLOCK); #1;
    POLL_REQ = 1'b0;
    ENABLE = 1'b0;
    valids = (VALID) ? 1 : 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge CLOCK); #1;
      if (VALID) valids++;
    end
    chk("coincide_valids", valids, 1);
    chk("coincide_buttons", {BUTTONS2, BUTTONS1}, 16'h9009);
    chk("coincide_pressed", {PRESSED2, PRESSED1}, {8'h90 & ~m_b2, 8'h09 & ~m_b1});

    // Reset during the 4th PULSE_HI.
    pad1 = 8'hFF;
    pad2 = 8'hFF;
    @(posedge CLOCK); #1;
    POLL_REQ = 1'b1;
    @(posedge CLOCK); #1;
    POLL_REQ = 1'b0;
    rises = 0;
    prev_p = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (PULSE && !prev_p) rises++;
      prev_p = PULSE;
      if (rises == 4) break;
      @(posedge CLOCK); #1;
    end
    chk("reach_4th_pulse", rises, 4);
    RESET_N = 1'b0;
    #1;
    chk("midrst_latch", LATCH, 1'b0);
    chk("midrst_pulse", PULSE, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_buttons", {BUTTONS2, BUTTONS1}, 16'h0000);
    chk("midrst_pressed", {PRESSED2, PRESSED1}, 16'h0000);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    valids = 0;
    busy_seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (VALID) valids++;
      if (BUSY) busy_seen++;
      @(posedge CLOCK); #1;
    end
    chk("midrst_no_valid", valids, 0);
    chk("midrst_no_busy", busy_seen, 0);
    m_b1 = 8'h00;
    m_b2 = 8'h00;

    // Randomized polls against the pad contents and previous report.
    for (int i = 0; i < 12; i++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      run_poll(r1, r2, r1, r2, r1 & ~m_b1, r2 & ~m_b2);
      m_b1 = r1;
      m_b2 = r2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_poll_scheduler.md
NES_POLL_SCHEDULER -- requirements
Module: nes_poll_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 162: a timing tick occurs every TICK_DIV+1 CLOCK cycles.
REQ-002 SHALL have parameter POLL_PERIOD, default 833333: CLOCK cycles between periodic polls (60 Hz at 50 MHz).
REQ-003 SHALL have port CLOCK  input  1  system clock; the only clock.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ENABLE  input  1  periodic polling enable.
REQ-006 SHALL have port POLL_REQ  input  1  single-cycle on-demand poll request.
REQ-007 SHALL have port DATA1, DATA2  input  1 each  serial data from pad 1 and pad 2, active low, asynchronous.
REQ-008 SHALL have port LATCH  output  1  latch line, shared by both pads.
REQ-009 SHALL have port PULSE  output  1  shift-clock line, shared by both pads.
REQ-010 SHALL have port BUSY  output  1  poll in progress.
REQ-011 SHALL have port BUTTONS1, BUTTONS2  output  8 each  held button state, 1 = pressed.
REQ-012 SHALL have port PRESSED1, PRESSED2  output  8 each  buttons newly pressed in the latest poll.
REQ-013 SHALL have port VALID  output  1  one-cycle strobe marking an update.

Function
REQ-014 SHALL pass DATA1 and DATA2 through a 2-flop synchronizer before any use.
REQ-015 SHALL implement states IDLE, LATCH_HI, LATCH_LO, PULSE_HI, PULSE_LO and DONE.
REQ-016 Tick counter SHALL restart at 0 on the cycle a poll starts; all state durations are counted in ticks.
REQ-017 IDLE -> LATCH_HI SHALL occur when POLL_REQ = 1 or a poll is pending; BUSY SHALL go high on the following cycle.
REQ-018 LATCH_HI SHALL hold LATCH = 1 and PULSE = 0 for 2 ticks, then go to LATCH_LO.
REQ-019 LATCH_LO SHALL hold LATCH = 0 for 1 tick.
REQ-020 On the last cycle of LATCH_LO, the block SHALL capture bit 0 of each pad as the inverted synchronized DATA.
REQ-021 PULSE_HI (PULSE = 1, 1 tick) and PULSE_LO (PULSE = 0, 1 tick) SHALL repeat 7 times under a 3-bit counter.
REQ-022 On the last cycle of each PULSE_LO, the block SHALL capture bits 1..7 in order.
REQ-023 Bit order SHALL be 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
REQ-024 A poll SHALL last exactly 17 ticks, i.e. 17*(TICK_DIV+1) cycles, from entering LATCH_HI to entering DONE.
REQ-025 DONE SHALL last 1 cycle and then return to IDLE.
REQ-026 In DONE, BUTTONSn SHALL be updated atomically from the shift registers.
REQ-027 In DONE, PRESSEDn SHALL be set to new & ~old.
REQ-028 In DONE, VALID SHALL be 1 for exactly that cycle; BUSY SHALL drop on the next cycle.
REQ-029 Outside DONE, BUTTONSn and PRESSEDn SHALL hold their values, and VALID SHALL be 0.
REQ-030 The period counter SHALL count 0..POLL_PERIOD-1 and wrap, free-running while ENABLE = 1.
REQ-031 The period counter SHALL clear and hold at 0 while ENABLE = 0.
REQ-032 Period expiry or POLL_REQ SHALL set a one-deep pending flag; further triggers SHALL coalesce into it.
REQ-033 The pending flag SHALL clear when a poll starts.
REQ-034 If POLL_REQ and period expiry coincide, the block SHALL start one poll only.
REQ-035 A trigger arriving while BUSY SHALL produce exactly one further poll after DONE.
REQ-036 LATCH and PULSE SHALL never both be 1, and both SHALL be 0 in IDLE and DONE.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 RESET_N = 0 SHALL immediately force state IDLE and clear the tick, period, bit and pending counters/flags.
REQ-039 RESET_N = 0 SHALL immediately force LATCH, PULSE, BUSY and VALID to 0 and BUTTONSn and PRESSEDn to 8'h00.
REQ-040 Reset mid-poll SHALL discard partial data; the first poll after release SHALL start only on a new trigger.

Structure
REQ-041 The shared package nes_pkg SHALL hold the state encoding, the button index constants (A..Right) and the default TICK_DIV.
REQ-042 One sub-module, nes_tick_gen, SHALL hold the prescaler, with inputs restart/enable and a one-cycle tick strobe output.

Verification (TICK_DIV = 3, POLL_PERIOD = 200)
REQ-043 Single poll: POLL_REQ pulse with DATA1 low in bit slots 0 and 7 and DATA2 always high -> LATCH high 8 cycles, 7 PULSE highs of 4 cycles each, VALID 68 cycles after start, BUTTONS1 = 8'h81, BUTTONS2 = 8'h00.
REQ-044 Edge detect: second poll with pad 1 pressing only A -> BUTTONS1 = 8'h01, PRESSED1 = 8'h00; a third poll adding Up -> PRESSED1 = 8'h10.
REQ-045 Periodic: ENABLE = 1, no POLL_REQ, for 1000 cycles -> exactly 5 VALID strobes spaced 200 cycles apart.
REQ-046 Coalescing: 3 POLL_REQ pulses during one BUSY window -> exactly one extra poll follows; 2 VALID strobes total.
REQ-047 Reset mid-poll: RESET_N low during the 4th PULSE_HI -> LATCH = PULSE = BUSY = 0 at once, BUTTONS = 8'h00, no VALID until the next trigger.
REQ-048 Protocol check: an assertion that LATCH and PULSE are never both 1 SHALL hold across all of the scenarios above.
